// File: rtl/fifo_result_reader.sv
// fifo_result_reader: pops 2N result words from a result FIFO (one-cycle
// read latency), assembles them into res_out[0..2N-1] in pop order and
// presents them with a valid/ready handshake. One operation at a time.
// Optional macro READER_CNT_EN adds an 8-bit wrapping count of completed
// transfers on op_count; without it op_count is tied to zero.
module fifo_result_reader #(
  parameter int N     = 2,
  parameter int WIDTH = 15 + N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             empty,
  output logic             rd_en,
  output logic [WIDTH-1:0] res_out [2*N-1:0],
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       op_count
);

  localparam int WORDS = 2 * N;
  localparam int CW    = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST    = CW'(WORDS);
  localparam logic [CW-1:0] LAST_M1 = CW'(WORDS - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state, state_nx;
  logic          armed;     // low until the first clock edge out of reset
  logic          rd_pend;   // a pop was issued last cycle; data is on fifo_dout now
  logic [CW-1:0] issued;
  logic [CW-1:0] captured;
  logic          xfer;

  assign xfer = (state == HOLD) && res_valid && res_ready;

  // Next-state: leave FILL on the edge the last word lands, leave HOLD on transfer
  always_comb begin
    state_nx = state;
    case (state)
      FILL: if (rd_pend && captured == LAST_M1) state_nx = HOLD;
      HOLD: if (xfer) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // Pop request: only while filling, FIFO has data and pops remain for this op
  always_comb begin
    rd_en = armed && (state == FILL) && !empty && (issued < LAST);
  end

  // Control state, pop/capture counters and registered valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      armed     <= 1'b0;
      rd_pend   <= 1'b0;
      issued    <= '0;
      captured  <= '0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      armed     <= 1'b1;
      rd_pend   <= rd_en;
      res_valid <= (state_nx == HOLD);
      if (xfer) begin
        issued   <= '0;
        captured <= '0;
      end else begin
        if (rd_en)   issued   <= issued + CW'(1);
        if (rd_pend) captured <= captured + CW'(1);
      end
    end
  end

  // Per-word result registers: each grabs fifo_dout when its index is next
  for (genvar k = 0; k < WORDS; k++) begin : g_word
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)
        res_out[k] <= '0;
      else if (rd_pend && captured == CW'(k))
        res_out[k] <= fifo_dout;
    end
  end

`ifdef READER_CNT_EN
  logic [7:0] op_cnt_q;

  // Completed-transfer counter, wraps naturally at 8 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      op_cnt_q <= '0;
    else if (xfer) op_cnt_q <= op_cnt_q + 8'd1;
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: doc/fifo_result_reader.md
FIFO_RESULT_READER -- requirements
Module: fifo_result_reader

Interface
REQ-001 SHALL have parameter N, default 2: array dimension; one operation yields 2N result words.
REQ-002 SHALL have parameter WIDTH, default 15+N: result word width, equal to the result FIFO data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fifo_dout  input  WIDTH  result FIFO read data, valid the cycle after rd_en.
REQ-006 SHALL have port empty  input  1  result FIFO empty flag.
REQ-007 SHALL have port rd_en  output  1  result FIFO pop request.
REQ-008 SHALL have port res_out  output  WIDTH x 2N (unpacked [2N-1:0])  assembled operation results.
REQ-009 SHALL have port res_valid  output  1  res_out holds a complete operation.
REQ-010 SHALL have port res_ready  input  1  consumer accepts res_out.
REQ-011 SHALL have port op_count  output  8  completed-transfer counter (see Configuration).

Function
REQ-012 SHALL implement states FILL and HOLD; reset state FILL.
REQ-013 In FILL, SHALL assert rd_en combinationally iff empty=0 and issued-pop count < 2N.
REQ-014 SHALL never assert rd_en while empty=1 or in HOLD.
REQ-015 SHALL capture fifo_dout exactly one cycle after each rd_en cycle (one-cycle read latency) into res_out[k], k = 0,1,...,2N-1 in pop order.
REQ-016 SHALL track issued pops (0..2N) and captured words (0..2N) with separate counters; back-to-back pops every cycle are legal.
REQ-017 SHALL move FILL->HOLD on the cycle the 2N-th word is captured; res_valid rises the following cycle and is registered.
REQ-018 In HOLD, SHALL hold res_out and res_valid=1 stable until the cycle res_valid=1 and res_ready=1 (transfer).
REQ-019 On transfer, SHALL return to FILL, clear both counters, drop res_valid next cycle; res_out retains last values until overwritten.
REQ-020 res_ready while res_valid=0 SHALL have no effect.
REQ-021 empty toggling mid-operation SHALL only stall popping; partial words already captured SHALL be kept and filling SHALL resume at the next index.
REQ-022 SHALL accept the earliest rd_en of the next operation no sooner than the cycle after the transfer (no overlap between operations).

Reset
REQ-023 On rst=0, SHALL asynchronously force state FILL, counters 0, rd_en=0, res_valid=0, all res_out words 0, op_count 0.
REQ-024 Reset asserted mid-operation SHALL discard partial words; a pop in flight at reset SHALL not be captured after release.
REQ-025 After rst deasserts, SHALL issue no rd_en before the first rising edge with rst=1.

Configuration
REQ-026 Macro READER_CNT_EN SHALL, when defined, make op_count increment by 1 on each transfer, wrapping 255->0.
REQ-027 Without READER_CNT_EN, op_count SHALL be constant 0 and no counter register SHALL exist; all other behaviour identical.

Verification (N=2, WIDTH=17)
REQ-028 FIFO preloaded 4 words 0x00011,0x00022,0x00033,0x00044, res_ready=1 -> rd_en 4 consecutive cycles, res_out[0..3]=0x00011..0x00044, res_valid 1 for one cycle.
REQ-029 Same data, res_ready=0 for 10 cycles -> res_valid held 1, res_out stable, rd_en 0 throughout HOLD even with FIFO non-empty.
REQ-030 FIFO holds 2 words then empty 5 cycles then 2 more -> rd_en exactly 4 pulses, no pop while empty=1, res_out in pop order.
REQ-031 rst=0 asynchronously after 3 captured words -> res_valid=0, res_out all 0 immediately; next 4 words form a fresh operation.
REQ-032 With READER_CNT_EN, 257 transfers -> op_count=1; without macro -> op_count=0.
REQ-033 Two operations back-to-back, res_ready=1 -> second operation's first rd_en no earlier than cycle after first transfer; res_out updates to second data set.
